// File: rtl/addi_ctrl.sv
// Multi-cycle controller for a single-instruction (addi) core: fetch, decode,
// register read, execute with signed-overflow trap, and register write-back.
module addi_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [5:0]  ADDI_OP       = 6'b001000,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [15:0] retired
);

    localparam int TO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        READ   = 3'd3,
        EXEC   = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    state_t state, next_state;

    logic [31:0]        pc;
    logic [31:0]        inst;
    logic signed [31:0] operand;
    logic signed [31:0] imm_ext;
    logic signed [31:0] sum;
    logic [TO_W-1:0]    to_cnt;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;

    logic       latch_inst;
    logic       capture_op;
    logic       retire;
    logic       to_inc;
    logic       trap_set;
    logic [1:0] cause_next;

    // Two's-complement overflow: like-signed operands yielding an opposite-signed result.
    function automatic logic add_overflow(input logic signed [31:0] a,
                                          input logic signed [31:0] b,
                                          input logic signed [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    assign opcode  = inst[31:26];
    assign rs      = inst[25:21];
    assign rt      = inst[20:16];
    assign imm     = inst[15:0];
    assign imm_ext = {{16{imm[15]}}, imm};
    assign sum     = operand + imm_ext;

    assign imem_addr = pc;
    assign busy      = (state != IDLE) && (state != TRAP);
    assign trap      = (state == TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        rf_raddr   = 5'd0;
        rf_we      = 1'b0;
        rf_waddr   = 5'd0;
        rf_wdata   = 32'd0;
        latch_inst = 1'b0;
        capture_op = 1'b0;
        retire     = 1'b0;
        to_inc     = 1'b0;
        trap_set   = 1'b0;
        cause_next = 2'd0;
        case (state)
            IDLE: begin
                if (start && !stop) next_state = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    latch_inst = 1'b1;
                    next_state = DECODE;
                end else if (to_cnt == TO_LAST) begin
                    trap_set   = 1'b1;
                    cause_next = CAUSE_TIMEOUT;
                    next_state = TRAP;
                end else begin
                    to_inc = 1'b1;
                end
            end
            DECODE: begin
                if (opcode == ADDI_OP) begin
                    next_state = READ;
                end else if (opcode == 6'd0) begin
                    retire     = 1'b1;
                    next_state = stop ? IDLE : FETCH;
                end else begin
                    trap_set   = 1'b1;
                    cause_next = CAUSE_ILLEGAL;
                    next_state = TRAP;
                end
            end
            READ: begin
                rf_raddr   = rs;
                capture_op = 1'b1;
                next_state = EXEC;
            end
            EXEC: begin
                if (add_overflow(operand, imm_ext, sum)) begin
                    trap_set   = 1'b1;
                    cause_next = CAUSE_OVERFLOW;
                    next_state = TRAP;
                end else begin
                    next_state = WB;
                end
            end
            WB: begin
                // Register 0 is hardwired: the write is suppressed but the instruction retires.
                rf_we      = (rt != 5'd0);
                rf_waddr   = rt;
                rf_wdata   = sum;
                retire     = 1'b1;
                next_state = stop ? IDLE : FETCH;
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            retired    <= 16'd0;
            trap_cause <= 2'd0;
            to_cnt     <= '0;
        end else begin
            if (retire) begin
                pc      <= pc + 32'd4;
                retired <= retired + 16'd1;
            end
            if (trap_set) trap_cause <= cause_next;
            // Counter idles at zero outside FETCH so every FETCH entry starts a fresh window.
            if (state != FETCH) begin
                to_cnt <= '0;
            end else if (to_inc) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latch_inst) inst <= imem_rdata;
        if (capture_op) operand <= rf_rdata;
    end

endmodule
